// File: rtl/riscv_data_pkg.sv
// Shared definitions for the RISC-V data port: width codes, lane masks,
// FSM state encoding and the load-result mask helper.
package riscv_data_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } port_state_t;

    // Keeps only the bits a load of the given width returns.
    // Stage-2 extension in the core then starts from bit 0.
    function automatic logic [31:0] width_mask(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: width_mask = 32'h0000_00FF;
            WIDTH_HALF: width_mask = 32'h0000_FFFF;
            default:    width_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_data_port_lane_align.sv
// riscv_lane_align: combinational lane logic shared by the RAM and MMIO paths.
// Produces byte enables, replicated store data, the right-shift offset for loads,
// and flags for misaligned accesses and the reserved width code.
module riscv_lane_align
    import riscv_data_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_width,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [1:0]  o_shift,
    output logic        o_misaligned,
    output logic        o_width_bad
);

    // Decode width and low address bits into lanes; misaligned offsets are truncated here.
    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0000_0000;
        o_shift      = 2'd0;
        o_misaligned = 1'b0;
        o_width_bad  = 1'b0;
        case (i_width)
            WIDTH_BYTE: begin
                o_be    = LANE_BYTE << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_shift = i_offset;
            end
            WIDTH_HALF: begin
                o_be         = LANE_HALF << {i_offset[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_shift      = {i_offset[1], 1'b0};
                o_misaligned = i_offset[0];
            end
            WIDTH_WORD: begin
                o_be         = LANE_WORD;
                o_wdata      = i_wdata;
                o_misaligned = |i_offset;
            end
            default: begin
                o_width_bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_data_port.sv
// riscv_data_port: data-side memory port behind the core's load/store stage.
// Addresses below MMIO_BASE hit an on-chip byte-enabled RAM (one-cycle loads);
// the rest go out over a valid/ready bus with a timeout.
// Build option: define DATA_PORT_ALIGN_CHECK_EN to reject misaligned half/word
// accesses instead of truncating the low address bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting core strobes, RAM accesses complete here
// ST_REQ  | MMIO request on the bus, waiting for bus_ready or timeout
// ST_RESP | MMIO read result presented on data_in for one cycle
module riscv_data_port
    import riscv_data_pkg::*;
#(
    parameter int          RAM_WORDS   = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int          BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic [1:0]  data_width,
    input  logic [31:0] data_out,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_in,
    output logic        data_wait,
    output logic        data_error,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int          AW       = $clog2(RAM_WORDS);
    localparam logic [15:0] CNT_LAST = 16'(BUS_TIMEOUT - 1);

`ifdef DATA_PORT_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    port_state_t r_state;
    port_state_t w_state_next;

    logic [31:0] r_ram [RAM_WORDS];

    logic [31:0] r_rd_word;
    logic [1:0]  r_rd_shift;
    logic [1:0]  r_rd_width;
    logic        r_err;
    logic [15:0] r_cnt;

    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic        r_bus_we;
    logic [1:0]  r_bus_shift;
    logic [1:0]  r_bus_width;

    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [1:0]    w_shift;
    logic          w_misaligned;
    logic          w_width_bad;
    logic          w_reject;
    logic          w_idle;
    logic          w_strobe;
    logic          w_go;
    logic          w_ram_sel;
    logic          w_ram_wr;
    logic          w_ram_rd;
    logic          w_mmio_go;
    logic          w_bus_done;
    logic          w_timeout;
    logic [AW-1:0] w_idx;

    riscv_lane_align u_lane_align (
        .i_offset     (data_address[1:0]),
        .i_width      (data_width),
        .i_wdata      (data_out),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_shift      (w_shift),
        .o_misaligned (w_misaligned),
        .o_width_bad  (w_width_bad)
    );

    assign w_reject  = w_width_bad | (ALIGN_CHECK & w_misaligned);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_strobe  = data_read | data_write;
    assign w_go      = w_idle & w_strobe & ~w_reject;
    assign w_ram_sel = (data_address < MMIO_BASE);
    // A store always wins over a simultaneous load.
    assign w_ram_wr  = w_go & w_ram_sel & data_write;
    assign w_ram_rd  = w_go & w_ram_sel & data_read & ~data_write;
    assign w_mmio_go = w_go & ~w_ram_sel;
    assign w_idx     = data_address[AW+1:2];

    assign data_wait  = (r_state == ST_REQ);
    assign bus_valid  = (r_state == ST_REQ);
    assign data_error = r_err;
    assign bus_addr   = r_bus_addr;
    assign bus_be     = r_bus_be;
    assign bus_wdata  = r_bus_wdata;
    assign bus_we     = r_bus_we;
    assign data_in    = (r_rd_word >> {r_rd_shift, 3'b000}) & width_mask(r_rd_width);

    // State register; reset drops any in-flight MMIO request immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state plus bus completion / timeout decode.
    always_comb begin
        w_state_next = r_state;
        w_bus_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mmio_go) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (bus_ready) begin
                    w_bus_done   = 1'b1;
                    w_state_next = r_bus_we ? ST_IDLE : ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = r_bus_we ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Cycles spent in REQ without bus_ready; cleared whenever the request ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                         r_cnt <= 16'd0;
        else if ((r_state == ST_REQ) && !w_bus_done && !w_timeout) r_cnt <= r_cnt + 16'd1;
        else                                               r_cnt <= 16'd0;
    end

    // Latch the MMIO request so bus outputs stay stable for the whole REQ phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_addr  <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_we    <= 1'b0;
            r_bus_shift <= 2'd0;
            r_bus_width <= WIDTH_BYTE;
        end else if (w_mmio_go) begin
            r_bus_addr  <= {data_address[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_bus_we    <= data_write;
            r_bus_shift <= w_shift;
            r_bus_width <= data_width;
        end
    end

    // RAM store port: only the enabled lanes are written. Contents survive reset.
    always_ff @(posedge clock) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Load result: RAM word, captured bus data, or all-ones on a timed-out read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_word  <= 32'h0000_0000;
            r_rd_shift <= 2'd0;
            r_rd_width <= WIDTH_BYTE;
        end else if (w_ram_rd) begin
            r_rd_word  <= r_ram[w_idx];
            r_rd_shift <= w_shift;
            r_rd_width <= data_width;
        end else if (w_bus_done && !r_bus_we) begin
            r_rd_word  <= bus_rdata;
            r_rd_shift <= r_bus_shift;
            r_rd_width <= r_bus_width;
        end else if (w_timeout && !r_bus_we) begin
            r_rd_word  <= 32'hFFFF_FFFF;
            r_rd_shift <= 2'd0;
            r_rd_width <= WIDTH_WORD;
        end
    end

    // One-cycle error pulse for rejected strobes, read/write collisions and timeouts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= (w_idle & w_strobe & (w_reject | (data_read & data_write))) | w_timeout;
    end

endmodule

// File: tb/tb_riscv_data_port.sv
// Directed self-checking bench for riscv_data_port (default parameters).
// Honours DATA_PORT_ALIGN_CHECK_EN when it is defined for the build.
module tb_riscv_data_port;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_in;
    logic        data_wait;
    logic        data_error;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          wcnt;
    int          hs;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        c_we;

    riscv_data_port dut (
        .clock        (clock),
        .reset        (reset),
        .data_address (data_address),
        .data_width   (data_width),
        .data_out     (data_out),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_in      (data_in),
        .data_wait    (data_wait),
        .data_error   (data_error),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_we       (bus_we),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One core access lasting a single cycle; returns #1 after the edge.
    task automatic ram_op(input logic rd, input logic wr, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] d);
        data_read    = rd;
        data_write   = wr;
        data_width   = w;
        data_address = a;
        data_out     = d;
        @(posedge clock); #1;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    // MMIO access; the core holds strobes while data_wait is high. bus_ready is
    // raised in the ready_after-th wait cycle (0 = never). Returns in cycle M+1.
    task automatic mmio_op(input logic rd, input logic wr, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] d,
                           input int ready_after, input logic [31:0] rdata,
                           output int o_wcnt, output int o_hs,
                           output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [3:0] o_be, output logic o_we);
        data_read    = rd;
        data_write   = wr;
        data_width   = w;
        data_address = a;
        data_out     = d;
        bus_rdata    = rdata;
        o_wcnt = 0; o_hs = 0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (!data_wait) break;
            o_wcnt++;
            if (o_wcnt == 1) begin
                o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
            end
            bus_ready = (o_wcnt == ready_after);
            if (bus_valid && bus_ready) o_hs++;
        end
        bus_ready  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        data_address = '0; data_width = 2'd0; data_out = '0;
        data_read = 1'b0; data_write = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        #12;
        check_eq("rst_data_in",  data_in, 32'h0);
        check_eq("rst_wait",     32'(data_wait), 32'h0);
        check_eq("rst_error",    32'(data_error), 32'h0);
        check_eq("rst_valid",    32'(bus_valid), 32'h0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_bus_be",   32'(bus_be), 32'h0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        // RAM store word, load byte at top lane
        ram_op(0, 1, 2'd2, 32'h10, 32'hDEADBEEF);
        ram_op(1, 0, 2'd0, 32'h13, 32'h0);
        check_eq("ld_byte_13", data_in, 32'h0000_00DE);
        check_eq("ld_byte_err", 32'(data_error), 32'h0);

        // Half store over all-ones
        ram_op(0, 1, 2'd2, 32'h20, 32'hFFFFFFFF);
        ram_op(0, 1, 2'd1, 32'h22, 32'h0000_1234);
        ram_op(1, 0, 2'd2, 32'h20, 32'h0);
        check_eq("ld_word_20", data_in, 32'h1234_FFFF);

        // Address wrap modulo RAM size (4096 words = 0x4000 bytes)
        ram_op(1, 0, 2'd2, 32'h4010, 32'h0);
        check_eq("ld_wrap", data_in, 32'hDEAD_BEEF);
        ram_op(1, 0, 2'd1, 32'h12, 32'h0);
        check_eq("ld_half_12", data_in, 32'h0000_DEAD);
        ram_op(1, 0, 2'd0, 32'h10, 32'h0);
        check_eq("ld_byte_10", data_in, 32'h0000_00EF);

        // Reserved width: error, no memory effect, data_in held
        ram_op(0, 1, 2'd3, 32'h10, 32'h0);
        check_eq("w3_err", 32'(data_error), 32'h1);
        check_eq("w3_hold", data_in, 32'h0000_00EF);
        @(posedge clock); #1;
        check_eq("w3_err_pulse", 32'(data_error), 32'h0);
        ram_op(1, 0, 2'd2, 32'h10, 32'h0);
        check_eq("w3_no_write", data_in, 32'hDEAD_BEEF);

        // Simultaneous strobes: write wins, error pulses
        ram_op(1, 1, 2'd2, 32'h30, 32'h55AA_55AA);
        check_eq("both_err", 32'(data_error), 32'h1);
        check_eq("both_hold", data_in, 32'hDEAD_BEEF);
        ram_op(1, 0, 2'd2, 32'h30, 32'h0);
        check_eq("both_written", data_in, 32'h55AA_55AA);

        // Misaligned accesses
        ram_op(0, 1, 2'd2, 32'h4, 32'h1122_3344);
        ram_op(1, 0, 2'd2, 32'h6, 32'h0);
`ifdef DATA_PORT_ALIGN_CHECK_EN
        check_eq("mis_word_data", data_in, 32'h55AA_55AA);
        check_eq("mis_word_err", 32'(data_error), 32'h1);
`else
        check_eq("mis_word_data", data_in, 32'h1122_3344);
        check_eq("mis_word_err", 32'(data_error), 32'h0);
`endif
        check_eq("mis_word_bus", 32'(bus_valid), 32'h0);
        ram_op(1, 0, 2'd1, 32'h5, 32'h0);
`ifdef DATA_PORT_ALIGN_CHECK_EN
        check_eq("mis_half_data", data_in, 32'h55AA_55AA);
        check_eq("mis_half_err", 32'(data_error), 32'h1);
`else
        check_eq("mis_half_data", data_in, 32'h0000_3344);
        check_eq("mis_half_err", 32'(data_error), 32'h0);
`endif

        // MMIO word write, ready in third wait cycle
        mmio_op(0, 1, 2'd2, 32'h8000_0004, 32'hCAFE_F00D, 3, 32'h0, wcnt, hs, c_addr, c_wdata, c_be, c_we);
        check_eq("mw_wait_cycles", 32'(wcnt), 32'd3);
        check_eq("mw_handshakes", 32'(hs), 32'd1);
        check_eq("mw_addr", c_addr, 32'h8000_0004);
        check_eq("mw_be", 32'(c_be), 32'hF);
        check_eq("mw_we", 32'(c_we), 32'h1);
        check_eq("mw_wdata", c_wdata, 32'hCAFE_F00D);
        check_eq("mw_err", 32'(data_error), 32'h0);
        @(posedge clock); #1;
        check_eq("mw_no_second_req", 32'(bus_valid), 32'h0);

        // MMIO byte write: lane replication and enable
        mmio_op(0, 1, 2'd0, 32'h8000_0002, 32'h0000_00A5, 1, 32'h0, wcnt, hs, c_addr, c_wdata, c_be, c_we);
        check_eq("mb_wait_cycles", 32'(wcnt), 32'd1);
        check_eq("mb_addr", c_addr, 32'h8000_0000);
        check_eq("mb_be", 32'(c_be), 32'h4);
        check_eq("mb_wdata", c_wdata, 32'hA5A5_A5A5);

        // MMIO byte read at offset 1
        mmio_op(1, 0, 2'd0, 32'h8000_0001, 32'h0, 2, 32'h00AB_CD00, wcnt, hs, c_addr, c_wdata, c_be, c_we);
        check_eq("mr_wait_cycles", 32'(wcnt), 32'd2);
        check_eq("mr_we", 32'(c_we), 32'h0);
        check_eq("mr_be", 32'(c_be), 32'h2);
        check_eq("mr_data", data_in, 32'h0000_00CD);
        @(posedge clock); #1;
        check_eq("mr_idle", 32'(data_wait), 32'h0);

        // MMIO read timeout
        mmio_op(1, 0, 2'd0, 32'h8000_0008, 32'h0, 0, 32'h0, wcnt, hs, c_addr, c_wdata, c_be, c_we);
        check_eq("to_wait_cycles", 32'(wcnt), 32'd255);
        check_eq("to_err", 32'(data_error), 32'h1);
        check_eq("to_data", data_in, 32'hFFFF_FFFF);
        check_eq("to_valid_drop", 32'(bus_valid), 32'h0);
        @(posedge clock); #1;
        check_eq("to_err_pulse", 32'(data_error), 32'h0);

        // Reset while in REQ
        data_read = 1'b1; data_width = 2'd2; data_address = 32'h8000_0010;
        @(posedge clock); #1;
        check_eq("rq_valid", 32'(bus_valid), 32'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_eq("rq_rst_valid", 32'(bus_valid), 32'h0);
        check_eq("rq_rst_wait", 32'(data_wait), 32'h0);
        check_eq("rq_rst_addr", bus_addr, 32'h0);
        check_eq("rq_rst_data", data_in, 32'h0);
        data_read = 1'b0;
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check_eq("rq_idle", 32'(data_wait), 32'h0);
        ram_op(1, 0, 2'd2, 32'h10, 32'h0);
        check_eq("ram_kept", data_in, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
